// File: rtl/match_result_buffer_if.sv
// Result-stream bundle: controller-side write stream (din/din_valid, no
// back-pressure) and sink-side FWFT valid/ready read stream.
interface match_result_buffer_if #(
  parameter int unsigned DATA_WIDTH = 60
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  // Buffer side: consumes din and m_ready, produces the head beat.
  modport slave (
    input  din, din_valid, m_ready,
    output m_data, m_valid, m_last
  );

  // Environment side: controller plus sink.
  modport master (
    output din, din_valid, m_ready,
    input  m_data, m_valid, m_last
  );
endinterface

// File: rtl/match_result_buffer.sv
// Captures the controller result stream into a small FWFT FIFO, frames it into
// FRAME_LEN-beat frames with a last-beat flag and reports dropped words.
module match_result_buffer #(
  parameter int unsigned DATA_WIDTH = 60,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  match_result_buffer_if.slave  bus,
  output logic [ADDR_WIDTH:0]   fill,
  output logic                  overflow,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned           DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  LEN_C  = CNT_WIDTH'(FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0]  LAST_C = CNT_WIDTH'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                  state_q;
  logic                    busy_q;
  logic                    frame_done_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   wptr_q;
  logic [ADDR_WIDTH-1:0]   rptr_q;
  logic [ADDR_WIDTH:0]     fill_q, fill_d;
  logic [CNT_WIDTH-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0]    out_cnt_q, out_cnt_d;
  logic                    overflow_q, overflow_d;

  logic full, empty, accepting, push, pop, drop, last_beat, open_frame;

  assign full       = (fill_q == FULL_C);
  assign empty      = (fill_q == '0);
  assign open_frame = (state_q == S_IDLE) && start;
  // Writes stop once the frame is complete, even before RUN hands over to DRAIN.
  assign accepting  = (state_q == S_RUN) && (in_cnt_q != LEN_C);
  assign pop        = !empty && bus.m_ready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign push       = accepting && bus.din_valid && (!full || pop);
  assign drop       = accepting && bus.din_valid && full && !pop;
  assign last_beat  = pop && bus.m_last;

  // Head word is gated to zero while empty so unreset storage never leaks out.
  assign bus.m_valid = !empty;
  assign bus.m_data  = empty ? '0 : mem_q[rptr_q];
  assign bus.m_last  = !empty && (out_cnt_q == LAST_C);

  assign fill       = fill_q;
  assign overflow   = overflow_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  // Next occupancy, frame counters and sticky drop flag.
  always_comb begin
    fill_d     = fill_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    overflow_d = overflow_q;
    if (open_frame) begin
      in_cnt_d   = '0;
      out_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) in_cnt_d  = in_cnt_q + 1'b1;
      if (pop)  out_cnt_d = out_cnt_q + 1'b1;
      if (drop) overflow_d = 1'b1;
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // FIFO storage; not reset, contents are only visible through a valid head.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.din;
  end

  // Pointers, occupancy and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_q     <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      fill_q     <= fill_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Frame sequencer with registered busy and frame_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          // Last beat can only leave in RUN once all FRAME_LEN words are in.
          if (last_beat) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end else if (in_cnt_q == LEN_C) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (last_beat) begin
            state_q      <= S_DONE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
